// File: rtl/circ_pkg.sv
// Shared constants and index helpers for the circulant transpose buffer.
// Rotations act on element indices within an N-element row (N power of two).
package circ_pkg;

  localparam logic MODE_TRANSPOSE = 1'b1;
  localparam logic MODE_PASS      = 1'b0;

  function automatic int addr_len(input int n);
    return $clog2(n);
  endfunction

  // element index i rotated left by k positions in an n-element row
  function automatic int rotate_left(
    input int i,
    input int k,
    input int n
  );
    return (i + k) & (n - 1);
  endfunction

  // element index i rotated right by k positions in an n-element row
  function automatic int rotate_right(
    input int i,
    input int k,
    input int n
  );
    return (i - k + n) & (n - 1);
  endfunction

endpackage

// File: rtl/circulant_bank_array.sv
// N simple dual-port element banks, shared write address, per-bank
// read address, one-cycle registered read port on every bank.
module circulant_bank_array #(
  parameter int NUM_BANKS = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH_LEN = 3
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [DEPTH_LEN-1:0]           wr_addr,
  input  logic [NUM_BANKS*WIDTH-1:0]     wr_data,
  input  logic                           rd_en,
  input  logic [NUM_BANKS*DEPTH_LEN-1:0] rd_addr,
  output logic [NUM_BANKS*WIDTH-1:0]     rd_data
);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] mem [2**DEPTH_LEN];
    logic [WIDTH-1:0] rdq;
    logic [DEPTH_LEN-1:0] ra;

    assign ra = rd_addr[b*DEPTH_LEN +: DEPTH_LEN];

    // bank storage: one write and one registered read per cycle
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data[b*WIDTH +: WIDTH];
      end
      if (rd_en) begin
        rdq <= mem[ra];
      end
    end

    assign rd_data[b*WIDTH +: WIDTH] = rdq;
  end

endmodule

// File: rtl/circulant_transpose_buffer.sv
// Ping-pong streaming matrix transpose over circulant-skewed banks.
// One row in per beat, one column (or row) out per beat.
module circulant_transpose_buffer
  import circ_pkg::*;
#(
  parameter int MATRIX_DIM = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ROW_WIDTH  = MATRIX_DIM * COL_WIDTH,
  parameter int ADDR_LEN   = addr_len(MATRIX_DIM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [ROW_WIDTH-1:0] s_data,
  input  logic                s_mode,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [ROW_WIDTH-1:0] m_data,
  output logic [ADDR_LEN-1:0] m_idx,
  output logic                m_last,
  output logic                err_len
);

  localparam int N  = MATRIX_DIM;
  localparam int W  = COL_WIDTH;
  localparam int DL = ADDR_LEN + 1;
  localparam logic [ADDR_LEN-1:0] LAST = ADDR_LEN'(N - 1);

  logic [1:0]          full, full_nxt;
  logic [1:0]          mode;
  logic                wr_page, rd_page;
  logic [ADDR_LEN-1:0] wr_cnt, rd_cnt;
  logic                accept, wr_done;
  logic                issue, rd_done, pop;
  logic                rd_transpose;
  logic [2:0]          slots;

  logic                inf_v, inf_last;
  logic [ADDR_LEN-1:0] inf_idx;

  logic [ROW_WIDTH-1:0] wr_data, rd_data, unskew;
  logic [N*DL-1:0]      rd_addr;

  logic [ROW_WIDTH-1:0] f_data [2];
  logic [ADDR_LEN-1:0]  f_idx  [2];
  logic                 f_last [2];
  logic                 head, tail;
  logic [1:0]           cnt;

  assign s_ready = !full[wr_page];
  assign accept  = s_valid && s_ready;
  assign wr_done = (wr_cnt == LAST);

  assign m_valid = (cnt != 2'd0);
  assign m_data  = f_data[head];
  assign m_idx   = f_idx[head];
  assign m_last  = f_last[head];
  assign pop     = m_valid && m_ready;
  assign tail    = head ^ cnt[0];

  // queue space counts the beat in flight and the beat leaving now
  assign slots   = {1'b0, cnt} + {2'b0, inf_v} - {2'b0, pop};
  assign issue   = full[rd_page] && (slots < 3'd2);
  assign rd_done = (rd_cnt == LAST);
  assign rd_transpose = (mode[rd_page] == MODE_TRANSPOSE);

  // skew: row r element c lands in bank (r+c) mod N
  always_comb begin
    wr_data = '0;
    for (int b = 0; b < N; b++) begin
      wr_data[b*W +: W] =
        s_data[rotate_right(b, int'(wr_cnt), N)*W +: W];
    end
  end

  // per-bank read row: diagonal for a column, flat for a row
  always_comb begin
    rd_addr = '0;
    for (int b = 0; b < N; b++) begin
      rd_addr[b*DL +: DL] = {rd_page, rd_transpose
        ? ADDR_LEN'(rotate_right(b, int'(rd_cnt), N))
        : rd_cnt};
    end
  end

  // unskew: output element r comes from bank (r+idx) mod N
  always_comb begin
    unskew = '0;
    for (int r = 0; r < N; r++) begin
      unskew[r*W +: W] =
        rd_data[rotate_left(r, int'(inf_idx), N)*W +: W];
    end
  end

  // page full flags: writer completion and reader release both apply
  always_comb begin
    full_nxt = full;
    if (accept && wr_done) full_nxt[wr_page] = 1'b1;
    if (issue && rd_done)  full_nxt[rd_page] = 1'b0;
  end

  circulant_bank_array #(
    .NUM_BANKS (N),
    .WIDTH     (W),
    .DEPTH_LEN (DL)
  ) u_banks (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr ({wr_page, wr_cnt}),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // page, counter, mode and length-error control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= '0;
      mode     <= '0;
      wr_page  <= 1'b0;
      rd_page  <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      err_len  <= 1'b0;
      inf_v    <= 1'b0;
      inf_idx  <= '0;
      inf_last <= 1'b0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        if (wr_cnt == '0) mode[wr_page] <= s_mode;
        if (s_last != wr_done) err_len <= 1'b1;
        if (wr_done) begin
          wr_page <= ~wr_page;
          wr_cnt  <= '0;
        end else begin
          wr_cnt  <= wr_cnt + 1'b1;
        end
      end
      if (issue) begin
        if (rd_done) begin
          rd_page <= ~rd_page;
          rd_cnt  <= '0;
        end else begin
          rd_cnt  <= rd_cnt + 1'b1;
        end
      end
      inf_v    <= issue;
      inf_idx  <= rd_cnt;
      inf_last <= rd_done;
    end
  end

  // two-entry output queue fed by the bank read pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= 1'b0;
      cnt  <= '0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_idx[i]  <= '0;
        f_last[i] <= 1'b0;
      end
    end else begin
      if (inf_v) begin
        f_data[tail] <= unskew;
        f_idx[tail]  <= inf_idx;
        f_last[tail] <= inf_last;
      end
      head <= head ^ pop;
      cnt  <= cnt + {1'b0, inf_v} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_circulant_transpose_buffer.sv
// Directed + randomized bench for circulant_transpose_buffer,
// outputs compared against a matrix-level reference queue.
module tb_circulant_transpose_buffer;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int RW = N * W;
  localparam int AL = 2;

  typedef logic [RW-1:0] mat_t [N];
  typedef struct {
    logic [RW-1:0] data;
    logic [AL-1:0] idx;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_mode = 1'b0;
  logic          s_last = 1'b0;
  logic [RW-1:0] s_data = '0;
  logic          m_ready = 1'b0;
  logic          s_ready, m_valid, m_last, err_len;
  logic [RW-1:0] m_data;
  logic [AL-1:0] m_idx;

  int    errors = 0;
  int    checks = 0;
  int    stalls = 0;
  int    ready_mode = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  circulant_transpose_buffer #(
    .MATRIX_DIM (N),
    .COL_WIDTH  (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_mode  (s_mode),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .m_last  (m_last),
    .err_len (err_len)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // consumer ready: 0 low, 1 high, 2 random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // output monitor: a handshake seen here completes at the next edge
  always @(negedge clk) begin
    beat_t e;
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", m_data, e.data);
        chk("m_idx", 64'(m_idx), 64'(e.idx));
        chk("m_last", 64'(m_last), 64'(e.last));
      end
    end
  end

  // reference: page content expressed as the matrix it represents
  task automatic model_push(input mat_t rows, input logic md);
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.data = '0;
      b.idx  = AL'(i);
      b.last = (i == N - 1);
      if (md) begin
        for (int r = 0; r < N; r++)
          b.data[r*W +: W] = rows[r][i*W +: W];
      end else begin
        b.data = rows[i];
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      stalls++;
      t++;
      if (t > 2000) begin
        chk("s_ready_timeout", 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "producer stuck");
      end
    end
  endtask

  task automatic send_row(
    input logic [RW-1:0] d,
    input logic          md,
    input logic          lst
  );
    s_valid = 1'b1;
    s_data  = d;
    s_mode  = md;
    s_last  = lst;
    wait_ready();
    @(posedge clk);
    #1;
  endtask

  task automatic send_matrix(
    input mat_t rows,
    input logic md,
    input int   last_at
  );
    logic m;
    model_push(rows, md);
    for (int r = 0; r < N; r++) begin
      m = (r == 0) ? md : 1'($urandom_range(0, 1));
      send_row(rows[r], m, r == last_at);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic rand_mat(output mat_t m);
    for (int r = 0; r < N; r++) m[r] = RW'($urandom());
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_empty", 64'(exp_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_m_valid", 64'(m_valid), 0);
  endtask

  initial begin
    mat_t mt, ma, mb, mc;
    logic [RW-1:0] hold_d;
    logic [AL-1:0] hold_i;

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mt[r][c*W +: W] = 8'(r * 16 + c);

    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_s_ready", 64'(s_ready), 1);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_idx", 64'(m_idx), 0);
    chk("rst_m_last", 64'(m_last), 0);
    chk("rst_err_len", 64'(err_len), 0);

    // transpose of the indexed matrix, with first-beat latency
    send_matrix(mt, 1'b1, N - 1);
    chk("lat_e0", 64'(m_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_e1", 64'(m_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_e2", 64'(m_valid), 1);
    chk("col0_direct", m_data, 64'h30201000);
    wait_drain(100);

    // passthrough of the same matrix
    send_matrix(mt, 1'b0, N - 1);
    wait_drain(100);
    chk("no_err_yet", 64'(err_len), 0);

    // three matrices back to back
    rand_mat(ma);
    send_matrix(ma, 1'b1, N - 1);
    stalls = 0;
    rand_mat(mb);
    send_matrix(mb, 1'b0, N - 1);
    rand_mat(mc);
    send_matrix(mc, 1'b1, N - 1);
    chk("pingpong_stalls", 64'(stalls), 0);
    wait_drain(100);

    // backpressure with both pages full
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rand_mat(ma);
    send_matrix(ma, 1'b1, N - 1);
    rand_mat(mb);
    send_matrix(mb, 1'b0, N - 1);
    repeat (4) @(negedge clk);
    chk("bp_s_ready", 64'(s_ready), 0);
    chk("bp_m_valid", 64'(m_valid), 1);
    hold_d = m_data;
    hold_i = m_idx;
    repeat (5) @(negedge clk);
    chk("bp_data_stable", m_data, hold_d);
    chk("bp_idx_stable", 64'(m_idx), 64'(hold_i));
    chk("bp_s_ready_hold", 64'(s_ready), 0);
    ready_mode = 2;
    rand_mat(mc);
    send_matrix(mc, 1'b1, N - 1);
    for (int k = 0; k < 4; k++) begin
      rand_mat(ma);
      send_matrix(ma, 1'($urandom_range(0, 1)), N - 1);
    end
    wait_drain(400);

    // mode latched per page
    ready_mode = 1;
    rand_mat(ma);
    send_matrix(ma, 1'b1, N - 1);
    rand_mat(mb);
    send_matrix(mb, 1'b0, N - 1);
    wait_drain(100);

    // early s_last: sticky error, count still governs completion
    send_matrix(mt, 1'b1, 2);
    chk("err_set", 64'(err_len), 1);
    wait_drain(100);
    rand_mat(ma);
    send_matrix(ma, 1'b0, N - 1);
    wait_drain(100);
    chk("err_sticky", 64'(err_len), 1);

    // reset in the middle of a page
    send_row(mt[0], 1'b1, 1'b0);
    send_row(mt[1], 1'b1, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid), 0);
    chk("mid_rst_s_ready", 64'(s_ready), 1);
    chk("mid_rst_err", 64'(err_len), 0);
    chk("mid_rst_m_data", m_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", 64'(s_ready), 1);
    send_matrix(mt, 1'b1, N - 1);
    wait_drain(100);
    chk("post_rst_err", 64'(err_len), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
